// File: rtl/karatsuba_seq_ctrl_if.sv
// rtl/karatsuba_seq_ctrl_if.sv - operand/product handshake bundle for the Karatsuba sequencer
// Signals:
//   a_in, b_in   WIDTH    operands, sampled on accept
//   in_valid     1        operand pair offered
//   in_ready     1        sequencer idle and able to accept
//   prod         2*WIDTH  product, stable while out_valid
//   out_valid    1        product available, held until taken
//   out_ready    1        sink takes product
//   busy         1        sequencer not idle
// Modports: master = operand source / product sink, slave = sequencer.
interface karatsuba_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] prod;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport master (
        output a_in, b_in, in_valid, out_ready,
        input  in_ready, prod, out_valid, busy
    );

    modport slave (
        input  a_in, b_in, in_valid, out_ready,
        output in_ready, prod, out_valid, busy
    );
endinterface

// File: rtl/karatsuba_seq_ctrl.sv
// rtl/karatsuba_seq_ctrl.sv - one-level Karatsuba multiply sequencer on a shared multiplier and adder
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   karatsuba_seq_ctrl_if.slave: operands in (valid/ready), product out (valid/ready), busy
// One (H+1)x(H+1) multiplier and one 2*WIDTH adder with carry-in are time-shared over
// M1..A2; prod = (k1<<WIDTH) + ((k3-k1-k2)<<H) + k2.
module karatsuba_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    karatsuba_seq_ctrl_if.slave  bus
);
    localparam int H  = WIDTH / 2;
    localparam int W2 = 2 * WIDTH;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_M1   = 4'd1;
    localparam logic [3:0] ST_M2   = 4'd2;
    localparam logic [3:0] ST_M3   = 4'd3;
    localparam logic [3:0] ST_S1   = 4'd4;
    localparam logic [3:0] ST_S2   = 4'd5;
    localparam logic [3:0] ST_A1   = 4'd6;
    localparam logic [3:0] ST_A2   = 4'd7;
    localparam logic [3:0] ST_OUT  = 4'd8;

    logic [3:0]       state;
    logic [H-1:0]     ah, al, bh, bl;
    logic [WIDTH-1:0] k1, k2;
    logic [WIDTH+1:0] k3;
    logic [W2-1:0]    t, mid, g, prod_r;
    logic             out_valid_r;

    logic [H:0]       mul_a, mul_b;
    logic [WIDTH+1:0] mul_p;
    logic [W2-1:0]    add_x, add_y;
    logic             add_cin;
    logic [W2:0]      add_full;
    logic             a2_carry;

    // Operand muxes are zero outside the owning states so the shared units stay quiet.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_M1: begin
                mul_a = {1'b0, ah};
                mul_b = {1'b0, bh};
            end
            ST_M2: begin
                mul_a = {1'b0, al};
                mul_b = {1'b0, bl};
            end
            ST_M3: begin
                // H+1-bit sums keep the carry out of ah+al
                mul_a = {1'b0, ah} + {1'b0, al};
                mul_b = {1'b0, bh} + {1'b0, bl};
            end
            default: ;
        endcase
    end

    assign mul_p = (WIDTH+2)'(mul_a) * (WIDTH+2)'(mul_b);

    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state)
            ST_S1: begin
                add_x   = W2'(k3);
                add_y   = ~W2'(k1);
                add_cin = 1'b1;
            end
            ST_S2: begin
                add_x   = t;
                add_y   = ~W2'(k2);
                add_cin = 1'b1;
            end
            ST_A1: begin
                add_x = W2'(k1) << WIDTH;
                add_y = mid << H;
            end
            ST_A2: begin
                add_x = g;
                add_y = W2'(k2);
            end
            default: ;
        endcase
    end

    assign add_full = {1'b0, add_x} + {1'b0, add_y} + {{W2{1'b0}}, add_cin};
    // Final accumulation can never overflow 2*WIDTH bits; any carry here is a datapath bug.
    assign a2_carry = (state == ST_A2) && add_full[W2];

    always @(posedge clk) begin
        if (!rst) begin
            assert (!a2_carry);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ah          <= '0;
            al          <= '0;
            bh          <= '0;
            bl          <= '0;
            k1          <= '0;
            k2          <= '0;
            k3          <= '0;
            t           <= '0;
            mid         <= '0;
            g           <= '0;
            prod_r      <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        ah    <= bus.a_in[WIDTH-1:H];
                        al    <= bus.a_in[H-1:0];
                        bh    <= bus.b_in[WIDTH-1:H];
                        bl    <= bus.b_in[H-1:0];
                        state <= ST_M1;
                    end
                end
                ST_M1: begin
                    k1    <= mul_p[WIDTH-1:0];
                    state <= ST_M2;
                end
                ST_M2: begin
                    k2    <= mul_p[WIDTH-1:0];
                    state <= ST_M3;
                end
                ST_M3: begin
                    k3    <= mul_p;
                    state <= ST_S1;
                end
                ST_S1: begin
                    t     <= add_full[W2-1:0];
                    state <= ST_S2;
                end
                ST_S2: begin
                    mid   <= add_full[W2-1:0];
                    state <= ST_A1;
                end
                ST_A1: begin
                    g     <= add_full[W2-1:0];
                    state <= ST_A2;
                end
                ST_A2: begin
                    prod_r      <= add_full[W2-1:0];
                    out_valid_r <= 1'b1;
                    state       <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.prod      = prod_r;
    assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// tb/tb_karatsuba_seq_ctrl.sv - self-checking bench for karatsuba_seq_ctrl
module tb_karatsuba_seq_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    karatsuba_seq_ctrl_if #(.WIDTH(W)) bus ();

    karatsuba_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a job is accepted when idle, its product a*b appears
    // 7 edges later and stays until taken; prod keeps its last value.
    bit              m_job;
    bit              m_valid;
    longint unsigned cyc;
    longint unsigned m_start;
    logic [63:0]     m_exp;
    logic [63:0]     m_last;

    initial begin
        cyc     = 0;
        m_job   = 0;
        m_valid = 0;
        m_start = 0;
        m_exp   = '0;
        m_last  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_job   = 0;
                m_valid = 0;
                m_last  = '0;
            end else if (!m_job) begin
                if (bus.in_valid) begin
                    m_job   = 1;
                    m_start = cyc;
                    m_exp   = 64'(bus.a_in) * 64'(bus.b_in);
                end
            end else if (!m_valid) begin
                if (cyc == m_start + 7) begin
                    m_valid = 1;
                    m_last  = m_exp;
                end
            end else if (bus.out_ready) begin
                m_valid = 0;
                m_job   = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy",      64'(bus.busy),      64'(m_job));
                check("in_ready",  64'(bus.in_ready),  64'(!m_job));
                check("out_valid", 64'(bus.out_valid), 64'(m_valid));
                check("prod",      bus.prod,           m_last);
                check("a2_carry",  64'(dut.a2_carry),  64'd0);
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                         input bit use_lit, input logic [63:0] lit,
                         input bit pulse, input bit pre_ready);
        int n;
        logic [63:0] p;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        bus.a_in      = a;
        bus.b_in      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = pre_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        if (pulse) begin
            // new operands offered during M2..A2 must be ignored
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                n++;
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.a_in     = $urandom;
                bus.b_in     = $urandom;
            end
            @(negedge clk);
            n++;
            bus.in_valid = 1'b0;
        end
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            check("out_valid_timeout", 64'd0, 64'd1);
            bus.out_ready = 1'b0;
            return;
        end
        check("latency", 64'(n), 64'd7);
        p = bus.prod;
        if (use_lit) check("lit_prod", p, lit);
        check("prod_ab", p, 64'(a) * 64'(b));
        if (!pre_ready) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("hold_prod",      bus.prod,            p);
                check("hold_out_valid", 64'(bus.out_valid),  64'd1);
                check("hold_in_ready",  64'(bus.in_ready),   64'd0);
            end
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("in_ready_after_take",  64'(bus.in_ready),  64'd1);
        check("out_valid_after_take", 64'(bus.out_valid), 64'd0);
        check("prod_after_take",      bus.prod,           p);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_prod",      bus.prod,            64'd0);
        check("rst_out_valid", 64'(bus.out_valid),  64'd0);
        check("rst_busy",      64'(bus.busy),       64'd0);
        check("rst_in_ready",  64'(bus.in_ready),   64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op(32'h00010002, 32'h00030004, 0, 1, 64'h00000003000A0008, 0, 1);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 64'hFFFFFFFE00000001, 0, 0);
        do_op(32'h00000000, 32'hDEADBEEF, 0, 1, 64'h0000000000000000, 0, 0);
        do_op(32'h00000001, 32'hFFFFFFFF, 0, 1, 64'h00000000FFFFFFFF, 0, 1);
        do_op(32'h12345678, 32'h9ABCDEF0, 5, 1, 64'h0B00EA4E242D2080, 0, 0);
        do_op(32'h0000FFFF, 32'h00010001, 2, 1, 64'h00000000FFFFFFFF, 1, 0);

        // asynchronous reset in the middle of S1
        @(negedge clk);
        bus.a_in     = 32'hCAFEBABE;
        bus.b_in     = 32'h87654321;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_prod",      bus.prod,           64'd0);
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_busy",      64'(bus.busy),      64'd0);
        check("arst_in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b0;
        do_op(32'd3, 32'd5, 0, 1, 64'd15, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       ra = 32'hFFFFFFFF;
                1:       ra = 32'h0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'hFFFFFFFF;
                1:       rb = 32'h0;
                default: rb = $urandom;
            endcase
            do_op(ra, rb, $urandom_range(0, 3), 0, 64'd0,
                  ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
